// File: rtl/intr_vec_pkg.sv
// rtl/intr_vec_pkg.sv - shared FSM type and mode constants for the interrupt vector controller
package intr_vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int PRIO_FIXED    = 0;
  localparam int PRIO_RR       = 1;

  localparam int ACK_TIMED     = 0;
  localparam int ACK_HANDSHAKE = 1;

endpackage

// File: rtl/intr_rr_select.sv
// rtl/intr_rr_select.sv - winner select over eligible sources, fixed or round-robin
module intr_rr_select
  import intr_vec_pkg::*;
#(
  parameter int PORTS       = 32,
  parameter int RR_PRIORITY = PRIO_FIXED,
  localparam int NUM_W      = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] i_eligible,
  input  logic [NUM_W-1:0] i_base,
  output logic             o_valid,
  output logic [NUM_W-1:0] o_winner
);

  logic [NUM_W-1:0] w_base;
  logic [PORTS-1:0] w_above;
  logic             w_above_valid;
  logic [NUM_W-1:0] w_above_idx;
  logic             w_all_valid;
  logic [NUM_W-1:0] w_all_idx;

  // Fixed priority parks the pointer on the top index so the upper search is always empty
  assign w_base = (RR_PRIORITY == PRIO_RR) ? i_base : NUM_W'(PORTS - 1);

  // Candidates strictly after the pointer get first chance; the rest wrap around
  always_comb begin
    w_above = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_above[i] = i_eligible[i] && (i > int'(w_base));
    end
  end

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1)
  ) u_pe_above (
    .i_unencoded (w_above),
    .o_valid     (w_above_valid),
    .o_encoded   (w_above_idx)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1)
  ) u_pe_all (
    .i_unencoded (i_eligible),
    .o_valid     (w_all_valid),
    .o_encoded   (w_all_idx)
  );

  assign o_valid  = w_all_valid;
  assign o_winner = w_above_valid ? w_above_idx : w_all_idx;

endmodule

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - combinational priority encoder with selectable winning end
module priority_encoder #(
  parameter int WIDTH             = 8,
  parameter int LSB_HIGH_PRIORITY = 1,
  localparam int IDX_W            = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_unencoded,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_encoded
);

  // Scan toward the preferred end so the last hit seen is the winner
  always_comb begin
    o_valid   = |i_unencoded;
    o_encoded = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_unencoded[i]) o_encoded = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_unencoded[i]) o_encoded = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_vec_ctrl.sv
// rtl/intr_vec_ctrl.sv - interrupt vector controller serialising sources into timed requests
module intr_vec_ctrl
  import intr_vec_pkg::*;
#(
  parameter int PORTS       = 32,
  parameter int HIGH_CYCLES = 3,
  parameter int LOW_CYCLES  = 64,
  parameter int CNT_WIDTH   = 8,
  parameter int RR_PRIORITY = PRIO_FIXED,
  parameter int ACK_MODE    = ACK_TIMED,
  localparam int NUM_W      = $clog2(PORTS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PORTS-1:0] i_intr,
  input  logic [PORTS-1:0] i_intr_edge,
  input  logic [PORTS-1:0] i_intr_mask,
  input  logic             i_intr_ack,
  output logic             o_intr_vec_req,
  output logic [NUM_W-1:0] o_intr_num,
  output logic [PORTS-1:0] o_intr_pending,
  output logic             o_intr_overflow
);

  localparam logic [CNT_WIDTH-1:0] HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LOW_LOAD  = CNT_WIDTH'(LOW_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PORTS-1:0] r_intr_d;
  logic [PORTS-1:0] r_pend;
  logic             r_req;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_last;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic             r_ovf;

  logic [PORTS-1:0] w_rise;
  logic [PORTS-1:0] w_pending;
  logic [PORTS-1:0] w_eligible;
  logic [PORTS-1:0] w_clr;
  logic             w_req_nxt;
  logic [NUM_W-1:0] w_num_nxt;
  logic [NUM_W-1:0] w_last_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic             w_win_valid;
  logic [NUM_W-1:0] w_winner;

  assign w_rise     = i_intr & ~r_intr_d & i_intr_edge;
  assign w_pending  = r_pend | (i_intr & ~i_intr_edge);
  assign w_eligible = w_pending & ~i_intr_mask;

  intr_rr_select #(
    .PORTS       (PORTS),
    .RR_PRIORITY (RR_PRIORITY)
  ) u_select (
    .i_eligible (w_eligible),
    .i_base     (r_last),
    .o_valid    (w_win_valid),
    .o_winner   (w_winner)
  );

  // Input history for edge detection; loads during reset too so a held-high input is not an edge
  always_ff @(posedge i_clk) begin
    r_intr_d <= i_intr;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-output logic: dispatch in IDLE, time or await ack in HIGH, enforce gap in LOW
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_num_nxt   = r_num;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_clr       = '0;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_req_nxt        = 1'b1;
          w_num_nxt        = w_winner;
          w_last_nxt       = w_winner;
          w_cnt_nxt        = HIGH_LOAD;
          w_clr[w_winner]  = 1'b1;
          w_state_nxt      = HIGH;
        end
      end
      HIGH: begin
        if (ACK_MODE == ACK_HANDSHAKE) begin
          if (i_intr_ack) begin
            w_req_nxt   = 1'b0;
            w_num_nxt   = '0;
            w_cnt_nxt   = LOW_LOAD;
            w_state_nxt = LOW;
          end
        end else if (r_cnt == CNT_ONE) begin
          w_req_nxt   = 1'b0;
          w_num_nxt   = '0;
          w_cnt_nxt   = LOW_LOAD;
          w_state_nxt = LOW;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      LOW: begin
        if (r_cnt == CNT_ONE) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_num_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs, counter, sticky pending (set beats clear) and overflow pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req  <= 1'b0;
      r_num  <= '0;
      r_last <= NUM_W'(PORTS - 1);
      r_cnt  <= '0;
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_req  <= w_req_nxt;
      r_num  <= w_num_nxt;
      r_last <= w_last_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      r_ovf  <= |(w_rise & r_pend);
    end
  end

  assign o_intr_vec_req  = r_req;
  assign o_intr_num      = r_num;
  assign o_intr_pending  = w_pending;
  assign o_intr_overflow = r_ovf;

endmodule

// File: tb/tb_intr_vec_ctrl.sv
// tb/tb_intr_vec_ctrl.sv - self-checking bench for intr_vec_ctrl against a behavioural model
module tb_intr_vec_ctrl;

  localparam int NI = 3;
  localparam int HC = 3;
  localparam int LC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] intr = 8'h00;
  logic [7:0] in_edge = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       ack = 1'b0;

  logic       req_w  [NI];
  logic [2:0] num_w  [NI];
  logic [7:0] pend_w [NI];
  logic       ovf_w  [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  intr_vec_ctrl #(.PORTS(8), .HIGH_CYCLES(HC), .LOW_CYCLES(LC), .CNT_WIDTH(8),
                  .RR_PRIORITY(0), .ACK_MODE(0)) u_fix (
    .i_clk(clk), .i_rst(rst), .i_intr(intr), .i_intr_edge(in_edge), .i_intr_mask(mask),
    .i_intr_ack(ack), .o_intr_vec_req(req_w[0]), .o_intr_num(num_w[0]),
    .o_intr_pending(pend_w[0]), .o_intr_overflow(ovf_w[0]));

  intr_vec_ctrl #(.PORTS(8), .HIGH_CYCLES(HC), .LOW_CYCLES(LC), .CNT_WIDTH(8),
                  .RR_PRIORITY(1), .ACK_MODE(0)) u_rr (
    .i_clk(clk), .i_rst(rst), .i_intr(intr), .i_intr_edge(in_edge), .i_intr_mask(mask),
    .i_intr_ack(ack), .o_intr_vec_req(req_w[1]), .o_intr_num(num_w[1]),
    .o_intr_pending(pend_w[1]), .o_intr_overflow(ovf_w[1]));

  intr_vec_ctrl #(.PORTS(8), .HIGH_CYCLES(HC), .LOW_CYCLES(LC), .CNT_WIDTH(8),
                  .RR_PRIORITY(0), .ACK_MODE(1)) u_ack (
    .i_clk(clk), .i_rst(rst), .i_intr(intr), .i_intr_edge(in_edge), .i_intr_mask(mask),
    .i_intr_ack(ack), .o_intr_vec_req(req_w[2]), .o_intr_num(num_w[2]),
    .o_intr_pending(pend_w[2]), .o_intr_overflow(ovf_w[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: instance 0 fixed/timed, 1 round-robin/timed, 2 fixed/handshake
  logic [7:0] m_prev [NI];
  logic [7:0] m_pend [NI];
  bit         m_req  [NI];
  int         m_num  [NI];
  bit         m_ovf  [NI];
  int         m_last [NI];
  int         m_phase[NI];   // 0 waiting, 1 request active, 2 quiet gap
  int         m_left [NI];
  logic [7:0] t_rise, t_elig, t_clr;
  int         t_w;

  function automatic int pick(input logic [7:0] e, input int base);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (base + k) % 8;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_prev[k] = intr; m_pend[k] = 8'h00; m_req[k] = 0; m_num[k] = 0;
        m_ovf[k] = 0; m_last[k] = 7; m_phase[k] = 0; m_left[k] = 0;
      end else begin
        t_rise = intr & ~m_prev[k] & in_edge;
        t_elig = (m_pend[k] | (intr & ~in_edge)) & ~mask;
        m_ovf[k] = |(t_rise & m_pend[k]);
        t_clr = 8'h00;
        if (m_phase[k] == 0) begin
          if (t_elig != 8'h00) begin
            t_w = pick(t_elig, (k == 1) ? m_last[k] : 7);
            m_req[k] = 1; m_num[k] = t_w; m_last[k] = t_w;
            t_clr[t_w] = 1'b1; m_phase[k] = 1; m_left[k] = HC;
          end
        end else if (m_phase[k] == 1) begin
          if (k == 2) begin
            if (ack) begin m_req[k] = 0; m_num[k] = 0; m_phase[k] = 2; m_left[k] = LC; end
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin m_req[k] = 0; m_num[k] = 0; m_phase[k] = 2; m_left[k] = LC; end
          end
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) m_phase[k] = 0;
        end
        m_pend[k] = (m_pend[k] & ~t_clr) | t_rise;
        m_prev[k] = intr;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("m_req%0d", k),  32'(req_w[k]),  32'(m_req[k]));
        chk($sformatf("m_num%0d", k),  32'(num_w[k]),  32'(m_num[k]));
        chk($sformatf("m_pend%0d", k), 32'(pend_w[k]), 32'(m_pend[k] | (intr & ~in_edge)));
        chk($sformatf("m_ovf%0d", k),  32'(ovf_w[k]),  32'(m_ovf[k]));
      end
    end
  end

  // Dispatch logs: source index captured on each request rising edge
  bit prev_req [NI];
  int q_fix[$];
  int q_rr[$];

  always @(negedge clk) begin
    if (req_w[0] && !prev_req[0]) q_fix.push_back(int'(num_w[0]));
    if (req_w[1] && !prev_req[1]) q_rr.push_back(int'(num_w[1]));
    for (int k = 0; k < NI; k++) prev_req[k] = req_w[k];
  end

  task automatic drive_slot();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive_slot(); rst = 1'b1; intr = 8'h00; mask = 8'h00; ack = 1'b0;
    drive_slot();
    drive_slot(); rst = 1'b0;
  endtask

  initial begin
    int ovf_cnt;
    int wait_n;
    @(negedge clk);
    cmp_en = 1;
    chk("rst_req", 32'(req_w[0]), 32'd0);
    chk("rst_num", 32'(num_w[0]), 32'd0);
    chk("rst_pend", 32'(pend_w[0]), 32'd0);

    // Fixed priority, two edges in one cycle
    #2; rst = 1'b0; in_edge = 8'hFF; mask = 8'h00; intr = 8'h00;
    drive_slot(); intr = 8'h0A;
    for (int i = 1; i <= 30; i++) begin
      bit er;
      int en;
      @(negedge clk);
      er = ((i >= 2) && (i <= 4)) || ((i >= 10) && (i <= 12));
      en = ((i >= 2) && (i <= 4)) ? 1 : (((i >= 10) && (i <= 12)) ? 3 : 0);
      chk("t1_req", 32'(req_w[0]), 32'(er));
      chk("t1_num", 32'(num_w[0]), 32'(en));
      if (i == 1)  chk("t1_pend_a", 32'(pend_w[0]), 32'h0A);
      if (i == 2)  chk("t1_pend_b", 32'(pend_w[0]), 32'h08);
      if (i == 10) chk("t1_pend_c", 32'(pend_w[0]), 32'h00);
    end

    // Masked source still captures, dispatches once unmasked
    do_reset();
    in_edge = 8'hFF; mask = 8'h02;
    drive_slot(); intr = 8'h02;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_noreq", 32'(req_w[0]), 32'd0);
    end
    chk("t2_pend1", 32'(pend_w[0][1]), 32'd1);
    #2; mask = 8'h00;
    @(negedge clk);
    chk("t2_req", 32'(req_w[0]), 32'd1);
    chk("t2_num", 32'(num_w[0]), 32'd1);

    // Level sources: round-robin alternates, fixed repeats lowest
    do_reset();
    in_edge = 8'h00; mask = 8'h00;
    q_fix.delete(); q_rr.delete();
    drive_slot(); intr = 8'h81;
    repeat (40) @(negedge clk);
    chk("t3_rr_cnt", 32'(q_rr.size() >= 4), 32'd1);
    chk("t3_fix_cnt", 32'(q_fix.size() >= 3), 32'd1);
    if (q_rr.size() >= 4) begin
      chk("t3_rr0", 32'(q_rr[0]), 32'd0);
      chk("t3_rr1", 32'(q_rr[1]), 32'd7);
      chk("t3_rr2", 32'(q_rr[2]), 32'd0);
      chk("t3_rr3", 32'(q_rr[3]), 32'd7);
    end
    if (q_fix.size() >= 3) begin
      chk("t3_fix0", 32'(q_fix[0]), 32'd0);
      chk("t3_fix1", 32'(q_fix[1]), 32'd0);
      chk("t3_fix2", 32'(q_fix[2]), 32'd0);
    end

    // Overflow on a second edge to an already pending, masked source
    do_reset();
    in_edge = 8'hFF; mask = 8'h04;
    q_fix.delete();
    drive_slot(); intr = 8'h04;
    drive_slot(); intr = 8'h00;
    drive_slot(); intr = 8'h04;
    ovf_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ovf_w[0]) ovf_cnt++;
    end
    chk("t4_ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("t4_pend2", 32'(pend_w[0][2]), 32'd1);
    #2; mask = 8'h00;
    repeat (30) @(negedge clk);
    chk("t4_disp_cnt", 32'(q_fix.size()), 32'd1);
    if (q_fix.size() == 1) chk("t4_disp_num", 32'(q_fix[0]), 32'd2);

    // Handshake mode: request held until ack, stray acks ignored
    do_reset();
    in_edge = 8'hFF; mask = 8'h00;
    drive_slot(); intr = 8'h01;
    wait_n = 0;
    while (!req_w[2] && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk("t5_req_seen", 32'(req_w[2]), 32'd1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t5_hold", 32'(req_w[2]), 32'd1);
    end
    #2; ack = 1'b1;
    @(negedge clk);
    chk("t5_drop", 32'(req_w[2]), 32'd0);
    #2; ack = 1'b0;
    drive_slot(); ack = 1'b1;
    drive_slot(); ack = 1'b0;
    repeat (8) drive_slot();
    ack = 1'b1;
    drive_slot(); ack = 1'b0;
    drive_slot(); intr = 8'h09;
    @(negedge clk);
    @(negedge clk);
    chk("t5_req2", 32'(req_w[2]), 32'd1);
    chk("t5_num2", 32'(num_w[2]), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold2", 32'(req_w[2]), 32'd1);
    end

    // Reset mid-pulse with the edge input held high
    do_reset();
    in_edge = 8'hFF; mask = 8'h00;
    drive_slot(); intr = 8'h10;
    @(negedge clk);
    @(negedge clk);
    chk("t6_req", 32'(req_w[0]), 32'd1);
    drive_slot(); rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_req", 32'(req_w[0]), 32'd0);
    chk("t6_rst_num", 32'(num_w[0]), 32'd0);
    chk("t6_rst_pend", 32'(pend_w[0]), 32'd0);
    #2; rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_quiet", 32'(req_w[0]), 32'd0);
    end
    #2; intr = 8'h00;
    drive_slot(); intr = 8'h10;
    @(negedge clk);
    @(negedge clk);
    chk("t6_redisp", 32'(req_w[0]), 32'd1);
    chk("t6_renum", 32'(num_w[0]), 32'd4);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive_slot();
      rst  = ($urandom_range(0, 199) == 0);
      intr = intr ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) in_edge = 8'($urandom);
      if ($urandom_range(0, 7) == 0)  mask = 8'($urandom);
      ack  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
